// File: rtl/xpb_reduce_accum.sv
// Segment sequencer and widened accumulator wrapped around the per-segment xpb ROM bank.
// Each issued segment's residue is added to the lower product part; the sum is published with a done pulse.
module xpb_reduce_accum #(
  parameter int WIDTH    = 1024,
  parameter int SEG_BITS = 5,
  parameter int NUM_SEG  = 8,
  parameter int ROM_LAT  = 1,
  parameter int SEL_W    = 3,
  parameter int ACC_W    = 1028
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [WIDTH-1:0]            base_i,
  input  logic [NUM_SEG*SEG_BITS-1:0] hi_i,
  output logic                        busy_o,
  output logic                        rom_valid_o,
  output logic [SEL_W-1:0]            rom_sel_o,
  output logic [SEG_BITS-1:0]         rom_addr_o,
  input  logic [WIDTH-1:0]            rom_data_i,
  output logic [ACC_W-1:0]            sum_o,
  output logic                        done_o
);
  // state | meaning
  // IDLE  | waiting for start_i
  // ISSUE | presenting segment seg_cnt to the ROM bank
  // DRAIN | waiting out ROM latency for the last residues
  // DONE  | sum_o final, done_o high; start_i may chain the next operation

  localparam int DR_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [NUM_SEG*SEG_BITS-1:0] hi_q;
  logic [SEL_W-1:0]            seg_cnt;
  logic [DR_W-1:0]             drain_cnt;
  logic [ROM_LAT-1:0]          vpipe;
  logic [ACC_W-1:0]            acc, acc_nxt;
  logic [SEG_BITS-1:0]         seg_val;
  logic                        accept, last_seg, drain_end;

  assign accept    = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign last_seg  = (seg_cnt == SEL_W'(NUM_SEG - 1));
  assign drain_end = (drain_cnt == DR_W'(1));
  assign acc_nxt   = vpipe[ROM_LAT-1] ? (acc + ACC_W'(rom_data_i)) : acc;

  always_comb begin
    seg_val = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (seg_cnt == SEL_W'(i)) seg_val = hi_q[i*SEG_BITS +: SEG_BITS];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    rom_valid_o = 1'b0;
    rom_sel_o   = '0;
    rom_addr_o  = '0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = ISSUE;
      end
      ISSUE: begin
        busy_o      = 1'b1;
        rom_valid_o = 1'b1;
        rom_sel_o   = seg_cnt;
        rom_addr_o  = seg_val;
        if (last_seg) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (drain_end) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = start_i ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // drain_end fires on the edge that brings the counter to zero, which is also the last add
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      seg_cnt   <= '0;
      drain_cnt <= '0;
      vpipe     <= '0;
      acc       <= '0;
      sum_o     <= '0;
    end else begin
      state_q  <= state_d;
      vpipe[0] <= rom_valid_o;
      for (int i = 1; i < ROM_LAT; i++) vpipe[i] <= vpipe[i-1];

      if (accept) begin
        hi_q    <= hi_i;
        acc     <= ACC_W'(base_i);
        seg_cnt <= '0;
      end else begin
        acc <= acc_nxt;
        if (state_q == ISSUE) seg_cnt <= last_seg ? '0 : seg_cnt + 1'b1;
      end

      if ((state_q == ISSUE) && last_seg) drain_cnt <= DR_W'(ROM_LAT);
      else if (state_q == DRAIN)          drain_cnt <= drain_cnt - 1'b1;

      if ((state_q == DRAIN) && drain_end) sum_o <= acc_nxt;
    end
  end

endmodule
